corr_pkt_decode: RTL and testbench

CORR_PKT_DECODE -- requirements
Module: corr_pkt_decode

---
 rtl/corr_pkt_decode_pkg.sv | 26 ++
 rtl/corr_pkt_decode_if.sv | 30 +++
 rtl/corr_pkt_decode_gap.sv | 39 +++
 rtl/corr_pkt_decode.sv | 63 ++++++
 tb/tb_corr_pkt_decode.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/corr_pkt_decode_pkg.sv
// corrPkt_pkg: packet layout and decoder state encodings shared by the correlator builder and decoder
package corrPkt_pkg;
  localparam int PKT_BYTES   = 5;
  localparam int IDX_WIN     = 0;
  localparam int IDX_X       = 1;
  localparam int IDX_Y       = 2;
  localparam int IDX_ISECT   = 3;
  localparam int IDX_SYMDIFF = 4;
  typedef enum logic [2:0] {
    S_WIN     = 3'd0,
    S_X       = 3'd1,
    S_Y       = 3'd2,
    S_ISECT   = 3'd3,
    S_SYMDIFF = 3'd4
  } state_t;
  typedef struct packed {
    logic [7:0] win_num;
    logic [7:0] count_x;
    logic [7:0] count_y;
    logic [7:0] count_isect;
    logic [7:0] count_symdiff;
  } pkt_rec_t;
  function automatic state_t next_state(input state_t s);
    return s == S_SYMDIFF ? S_WIN : state_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/corr_pkt_decode_if.sv
// corr_pkt_decode_if: bytepipe input, decoded record handshake and gap status of the packet decoder
interface corr_pkt_decode_if #(
  parameter int CNTR_W = 8
);
  logic              i_cg;
  logic              i_flush;
  logic [7:0]        i_bp_data;
  logic              i_bp_valid;
  logic              o_bp_ready;
  logic [7:0]        o_winNum;
  logic [7:0]        o_countX;
  logic [7:0]        o_countY;
  logic [7:0]        o_countIsect;
  logic [7:0]        o_countSymdiff;
  logic              o_pkt_valid;
  logic              i_pkt_ready;
  logic              o_gap;
  logic [7:0]        o_gapSize;
  logic [CNTR_W-1:0] o_gapCount;
  modport master (
    output i_cg, i_flush, i_bp_data, i_bp_valid, i_pkt_ready,
    input  o_bp_ready, o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff,
           o_pkt_valid, o_gap, o_gapSize, o_gapCount
  );
  modport slave (
    input  i_cg, i_flush, i_bp_data, i_bp_valid, i_pkt_ready,
    output o_bp_ready, o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff,
           o_pkt_valid, o_gap, o_gapSize, o_gapCount
  );
endinterface

// File: rtl/corr_pkt_decode_gap.sv
// corrPktGapCheck: tracks winNum continuity across loaded records and counts discontinuities
module corrPktGapCheck #(
  parameter int CNTR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        win_num,
  input  logic              load,
  input  logic              flush,
  output logic              gap,
  output logic [7:0]        gap_size,
  output logic [CNTR_W-1:0] gap_count
);
  logic       seen;
  logic [7:0] prev_win;
  logic [7:0] d;
  assign d = win_num - prev_win - 8'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seen      <= 1'b0;
      prev_win  <= '0;
      gap       <= 1'b0;
      gap_size  <= '0;
      gap_count <= '0;
    end else if (en) begin
      gap <= 1'b0;
      if (flush) seen <= 1'b0;
      else if (load) begin
        seen     <= 1'b1;
        prev_win <= win_num;
        if (seen && d != 8'd0) begin
          gap       <= 1'b1;
          gap_size  <= d;
          gap_count <= &gap_count ? gap_count : gap_count + CNTR_W'(1);
        end
      end
    end
endmodule

// File: rtl/corr_pkt_decode.sv
// corr_pkt_decode: assembles 5-byte correlator packets from a bytepipe into a handshaked record
module corr_pkt_decode
  import corrPkt_pkg::*;
#(
  parameter int CNTR_W  = 8,
  parameter int PKT_LEN = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  corr_pkt_decode_if.slave bus
);
  if (PKT_LEN != PKT_BYTES) begin : g_len_check
    $error("corr_pkt_decode: PKT_LEN must be %0d", PKT_BYTES);
  end
  state_t                       state_q, state_d;
  logic [0:PKT_BYTES-2][7:0]    asm_q;
  pkt_rec_t                     rec_q;
  logic                         valid_q;
  logic                         xfer;
  logic                         load;
  // the last byte stalls only while the previous record is still unclaimed
  assign bus.o_bp_ready = !(state_q == S_SYMDIFF && valid_q && !bus.i_pkt_ready);
  assign xfer = bus.i_bp_valid && bus.o_bp_ready && bus.i_cg && !bus.i_flush;
  assign load = xfer && state_q == S_SYMDIFF;
  always_comb begin
    state_d = state_q;
    if (bus.i_flush) state_d = S_WIN;
    else if (xfer) state_d = next_state(state_q);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= S_WIN;
    else if (bus.i_cg) state_q <= state_d;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      asm_q   <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.i_cg) begin
      if (xfer && state_q != S_SYMDIFF) asm_q[state_q[1:0]] <= bus.i_bp_data;
      if (bus.i_flush) valid_q <= 1'b0;
      else if (load) begin
        rec_q   <= {asm_q, bus.i_bp_data};
        valid_q <= 1'b1;
      end else if (bus.i_pkt_ready) valid_q <= 1'b0;
    end
  corrPktGapCheck #(.CNTR_W(CNTR_W)) u_gap (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .en        (bus.i_cg),
    .win_num   (asm_q[IDX_WIN]),
    .load      (load),
    .flush     (bus.i_flush),
    .gap       (bus.o_gap),
    .gap_size  (bus.o_gapSize),
    .gap_count (bus.o_gapCount)
  );
  assign bus.o_pkt_valid    = valid_q;
  assign bus.o_winNum       = rec_q.win_num;
  assign bus.o_countX       = rec_q.count_x;
  assign bus.o_countY       = rec_q.count_y;
  assign bus.o_countIsect   = rec_q.count_isect;
  assign bus.o_countSymdiff = rec_q.count_symdiff;
endmodule

// File: tb/tb_corr_pkt_decode.sv
// tb_corr_pkt_decode: vector table, corner sequences and randomized stream against a packet-level model
module tb_corr_pkt_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  corr_pkt_decode_if #(.CNTR_W(8)) bus ();
  corr_pkt_decode #(.CNTR_W(8), .PKT_LEN(5)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [39:0] pkt;
    logic        gap;
    logic [7:0]  size;
    logic [7:0]  count;
  } vec_t;
  vec_t tbl [8];
  int checks = 0;
  int failures = 0;
  logic        m_seen;
  logic [7:0]  m_prev, m_size, m_count;
  logic [39:0] exp_q[$], got_q[$];
  logic [7:0]  exp_gap_q[$], got_gap_q[$];
  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [39:0] rec();
    return {bus.o_winNum, bus.o_countX, bus.o_countY, bus.o_countIsect, bus.o_countSymdiff};
  endfunction
  task automatic model_pkt(input logic [39:0] p);
    int d;
    d = (int'(p[39:32]) - int'(m_prev) + 255) % 256;
    if (m_seen && d != 0) begin
      exp_gap_q.push_back(8'(d));
      m_size = 8'(d);
      if (m_count != 8'hFF) m_count = m_count + 8'd1;
    end
    m_seen = 1'b1;
    m_prev = p[39:32];
    exp_q.push_back(p);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_bp_data = b;
    bus.i_bp_valid = 1'b1;
    while (!bus.o_bp_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("bp_ready_timeout", 40'(bus.o_bp_ready), 40'd1);
    @(negedge clk);
    bus.i_bp_valid = 1'b0;
  endtask
  task automatic send_pkt(input logic [39:0] p);
    model_pkt(p);
    for (int k = 0; k < 5; k++) send_byte(p[39-8*k -: 8]);
  endtask
  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    exp_gap_q.delete();
    got_gap_q.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary, checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    time t0;
    logic [39:0] p1, p2;
    logic [7:0] last_w;
    tbl[0] = '{pkt:40'h0010203040, gap:1'b0, size:8'h00, count:8'h00};
    tbl[1] = '{pkt:40'h0111213141, gap:1'b0, size:8'h00, count:8'h00};
    tbl[2] = '{pkt:40'h05A1B2C3D4, gap:1'b1, size:8'h03, count:8'h01};
    tbl[3] = '{pkt:40'h0912345678, gap:1'b1, size:8'h03, count:8'h02};
    tbl[4] = '{pkt:40'hFF00FF00FF, gap:1'b1, size:8'hF5, count:8'h03};
    tbl[5] = '{pkt:40'h00DEADBEEF, gap:1'b0, size:8'hF5, count:8'h03};
    tbl[6] = '{pkt:40'h0201020304, gap:1'b1, size:8'h01, count:8'h04};
    tbl[7] = '{pkt:40'h02CAFEF00D, gap:1'b1, size:8'hFF, count:8'h05};
    m_seen = 1'b0; m_prev = 8'h00; m_size = 8'h00; m_count = 8'h00;
    bus.i_cg = 1'b1; bus.i_flush = 1'b0; bus.i_bp_data = 8'h00;
    bus.i_bp_valid = 1'b0; bus.i_pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 40'(bus.o_pkt_valid), 40'd0);
    chk("rst_fields", rec(), 40'd0);
    chk("rst_gap", {bus.o_gap, bus.o_gapSize, bus.o_gapCount}, 40'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_rst", 40'(bus.o_bp_ready), 40'd1);
    foreach (tbl[v]) begin
      t0 = $time;
      send_pkt(tbl[v].pkt);
      chk($sformatf("tbl%0d_cycles", v), 40'(($time - t0) / 10), 40'd5);
      chk($sformatf("tbl%0d_valid", v), 40'(bus.o_pkt_valid), 40'd1);
      chk($sformatf("tbl%0d_fields", v), rec(), tbl[v].pkt);
      chk($sformatf("tbl%0d_gap", v), 40'(bus.o_gap), 40'(tbl[v].gap));
      chk($sformatf("tbl%0d_size", v), 40'(bus.o_gapSize), 40'(tbl[v].size));
      chk($sformatf("tbl%0d_count", v), 40'(bus.o_gapCount), 40'(tbl[v].count));
    end
    @(negedge clk);
    bus.i_pkt_ready = 1'b0;
    p1 = 40'h0311111111;
    p2 = 40'h0422222222;
    send_pkt(p1);
    model_pkt(p2);
    for (int k = 0; k < 4; k++) send_byte(p2[39-8*k -: 8]);
    bus.i_bp_data = p2[7:0];
    bus.i_bp_valid = 1'b1;
    chk("bp_stall_ready", 40'(bus.o_bp_ready), 40'd0);
    repeat (3) @(negedge clk);
    chk("bp_stall_hold", {7'd0, bus.o_bp_ready, bus.o_pkt_valid, rec()[31:0]}, {7'd0, 1'b0, 1'b1, p1[31:0]});
    chk("bp_stall_win", 40'(bus.o_winNum), 40'h03);
    bus.i_pkt_ready = 1'b1;
    @(negedge clk);
    bus.i_bp_valid = 1'b0;
    chk("bp_release_valid", 40'(bus.o_pkt_valid), 40'd1);
    chk("bp_release_fields", rec(), p2);
    bus.i_pkt_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(8'h50 + 8'(k));
    bus.i_flush = 1'b1;
    bus.i_bp_data = 8'hEE;
    bus.i_bp_valid = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_bp_valid = 1'b0;
    m_seen = 1'b0;
    chk("flush_valid", 40'(bus.o_pkt_valid), 40'd0);
    chk("flush_keeps_gap", {bus.o_gapSize, bus.o_gapCount}, 40'hFF05);
    bus.i_pkt_ready = 1'b1;
    send_pkt(40'h0717273747);
    chk("post_flush_fields", rec(), 40'h0717273747);
    chk("post_flush_gap", {bus.o_gap, bus.o_gapCount}, 40'h005);
    bus.i_cg = 1'b0;
    bus.i_bp_data = 8'hAA;
    bus.i_bp_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("cg_hold_valid", 40'(bus.o_pkt_valid), 40'd1);
    bus.i_bp_valid = 1'b0;
    bus.i_cg = 1'b1;
    @(negedge clk);
    send_pkt(40'h08090A0B0C);
    chk("cg_no_transfer", rec(), 40'h08090A0B0C);
    @(negedge clk);
    clear_queues();
    last_w = 8'h08;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [7:0] w;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          w = $urandom_range(0, 9) < 7 ? last_w + 8'd1 : 8'($urandom);
          last_w = w;
          send_pkt({w, 32'($urandom)});
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got_q.size() < 60 && cyc < 4000) begin
          @(posedge clk);
          #1;
          if (bus.o_gap) got_gap_q.push_back(bus.o_gapSize);
          bus.i_pkt_ready = 1'($urandom_range(0, 1));
          if (bus.o_pkt_valid && bus.i_pkt_ready) got_q.push_back(rec());
          cyc++;
        end
      end
    join
    @(negedge clk);
    bus.i_pkt_ready = 1'b1;
    chk("rand_rec_count", 40'(got_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rand_rec%0d", i), got_q[i], exp_q[i]);
    chk("rand_gap_count", 40'(got_gap_q.size()), 40'(exp_gap_q.size()));
    for (int i = 0; i < got_gap_q.size() && i < exp_gap_q.size(); i++)
      chk($sformatf("rand_gap%0d", i), 40'(got_gap_q[i]), 40'(exp_gap_q[i]));
    chk("rand_final_gap", {bus.o_gapSize, bus.o_gapCount}, {24'd0, m_size, m_count});
    for (int n = 0; n < 301; n++) send_pkt({n[0] ? 8'h80 : 8'h00, 32'h01020304});
    chk("sat_count", 40'(bus.o_gapCount), 40'hFF);
    chk("sat_size", 40'(bus.o_gapSize), 40'h7F);
    clear_queues();
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fields", rec(), 40'd0);
    chk("async_rst_status", {bus.o_pkt_valid, bus.o_gap, bus.o_gapSize, bus.o_gapCount}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_seen = 1'b0; m_size = 8'h00; m_count = 8'h00;
    chk("bp_ready_after_rst2", 40'(bus.o_bp_ready), 40'd1);
    send_pkt(40'h3344556677);
    chk("post_rst_fields", rec(), 40'h3344556677);
    chk("post_rst_gap", {bus.o_pkt_valid, bus.o_gap, bus.o_gapCount}, 40'h200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
